// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio sample scheduler:
//   - state_e       : scheduler FSM states
//   - addr_t        : 17-bit audio ROM address
//   - SILENT_ADDR   : address presented while nothing is playing
//   - BGM_START/END : inclusive address ranges of the four background tracks
//   - SFX_START/END : inclusive address ranges of the three sound effects
// -----------------------------------------------------------------------------
package audio_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    BGM       = 2'd2,
    SFX       = 2'd3
  } state_e;

  localparam int ADDR_W  = 17;
  localparam int BGM_NUM = 4;
  localparam int SFX_NUM = 3;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t      SILENT_ADDR  = 17'h1FFFF;
  localparam logic [2:0] TRACK_SILENT = 3'd7;

  // ROM layout: four music tracks followed by three short effects.
  // NOTE: these are constant lookup tables, not storage, so there is nothing to reset.
  localparam addr_t BGM_START [BGM_NUM] = '{17'd0,     17'd46095, 17'd80000, 17'd100000};
  localparam addr_t BGM_END   [BGM_NUM] = '{17'd46094, 17'd79999, 17'd99999, 17'd119999};
  localparam addr_t SFX_START [SFX_NUM] = '{17'd120000, 17'd120032, 17'd120080};
  localparam addr_t SFX_END   [SFX_NUM] = '{17'd120031, 17'd120079, 17'd120143};

endpackage

// File: rtl/audio_scheduler_if.sv
// -----------------------------------------------------------------------------
// audio_scheduler_if
// Codec / request bus of the audio scheduler.
//   Inputs to the scheduler : INIT_FINISH, data_over, bgm_en, bgm_sel, sfx_req
//   Outputs of the scheduler: INIT, Add, sfx_ack, sfx_busy, track_id
// modport slave  : the scheduler itself
// modport master : whoever drives requests and the codec handshake
// -----------------------------------------------------------------------------
interface audio_scheduler_if #(
  parameter int SFX_N = 3
);
  logic             INIT_FINISH;
  logic             data_over;
  logic             bgm_en;
  logic [1:0]       bgm_sel;
  logic [SFX_N-1:0] sfx_req;

  logic             INIT;
  logic [16:0]      Add;
  logic [SFX_N-1:0] sfx_ack;
  logic             sfx_busy;
  logic [2:0]       track_id;

  modport slave (
    input  INIT_FINISH, data_over, bgm_en, bgm_sel, sfx_req,
    output INIT, Add, sfx_ack, sfx_busy, track_id
  );

  modport master (
    output INIT_FINISH, data_over, bgm_en, bgm_sel, sfx_req,
    input  INIT, Add, sfx_ack, sfx_busy, track_id
  );
endinterface

// File: rtl/audio_rate_div.sv
// -----------------------------------------------------------------------------
// audio_rate_div
// Sample-rate divider: counts 0..DIV-1 while run=1 and pulses tick on the
// last count. While run=0 the counter is held at 0, so playback always
// starts a full sample period after it is enabled.
//   Clk   : system clock
//   Reset : asynchronous active-low reset
//   run   : counter enable (scheduler is playing)
//   tick  : one-cycle sample strobe
// -----------------------------------------------------------------------------
module audio_rate_div #(
  parameter int DIV = 126
) (
  input  logic Clk,
  input  logic Reset,
  input  logic run,
  output logic tick
);

  localparam int             CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!run || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/audio_scheduler.sv
// -----------------------------------------------------------------------------
// audio_scheduler
// Chooses which audio ROM region feeds the codec: background music (BGM),
// a one-shot sound effect (SFX) or silence, and steps the sample address
// once per sample tick when the codec is ready.
//   Clk   : system clock, all state on the rising edge
//   Reset : asynchronous active-low reset
//   bus   : audio_scheduler_if.slave (codec handshake, requests, Add/track_id)
// An SFX interrupts BGM; the BGM position is saved and resumed when the SFX
// ends. A lower-index SFX preempts a playing one without touching the save.
// -----------------------------------------------------------------------------
module audio_scheduler
  import audio_pkg::*;
#(
  parameter int DIV   = 126,
  parameter int SFX_N = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  audio_scheduler_if.slave bus
);

  state_e           state_q, state_d;
  addr_t            add_q, add_d;
  addr_t            save_add_q, save_add_d;
  logic [2:0]       track_q, track_d;
  logic [1:0]       sfx_q, sfx_d;
  logic [1:0]       save_trk_q, save_trk_d;
  logic             save_vld_q, save_vld_d;
  logic [SFX_N-1:0] ack_q, ack_d;
  logic             init_q;

  logic             tick;
  logic             run;
  logic             req_vld;
  logic [1:0]       req_idx;
  logic             take_req;
  logic             sfx_done;
  logic [1:0]       bgm_cur;

  assign run     = (state_q == BGM) || (state_q == SFX);
  assign bgm_cur = track_q[1:0];

  audio_rate_div #(.DIV(DIV)) u_rate_div (
    .Clk   (Clk),
    .Reset (Reset),
    .run   (run),
    .tick  (tick)
  );

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    add_d      = add_q;
    track_d    = track_q;
    sfx_d      = sfx_q;
    save_add_d = save_add_q;
    save_trk_d = save_trk_q;
    save_vld_d = save_vld_q;
    ack_d      = '0;
    take_req   = 1'b0;

    // Priority encoder: scanning downwards leaves the lowest set index.
    req_vld = 1'b0;
    req_idx = '0;
    for (int i = SFX_N - 1; i >= 0; i--) begin
      if (bus.sfx_req[i]) begin
        req_vld = 1'b1;
        req_idx = 2'(i);
      end
    end

    sfx_done = (state_q == SFX) && tick && bus.data_over && (add_q == SFX_END[sfx_q]);

    case (state_q)
      WAIT_INIT: begin
        if (bus.INIT_FINISH) begin
          state_d = IDLE;
          add_d   = SILENT_ADDR;
          track_d = TRACK_SILENT;
        end
      end

      IDLE: begin
        take_req = req_vld;
        if (bus.bgm_en) begin
          state_d = BGM;
          add_d   = BGM_START[bus.bgm_sel];
          track_d = {1'b0, bus.bgm_sel};
        end
      end

      BGM: begin
        take_req = req_vld;
        if (tick) begin
          if (!bus.bgm_en) begin
            state_d = IDLE;
            add_d   = SILENT_ADDR;
            track_d = TRACK_SILENT;
          end else if (bus.bgm_sel != bgm_cur) begin
            add_d   = BGM_START[bus.bgm_sel];
            track_d = {1'b0, bus.bgm_sel};
          end else if (bus.data_over) begin
            add_d = (add_q == BGM_END[bgm_cur]) ? BGM_START[bgm_cur] : add_q + addr_t'(1);
          end
        end
      end

      SFX: begin
        // Only a strictly higher-priority request may preempt; on the final
        // sample the effect is finishing anyway, so any request is taken.
        take_req = req_vld && (sfx_done || (req_idx < sfx_q));
        if (sfx_done) begin
          save_vld_d = 1'b0;
          if (bus.bgm_en) begin
            state_d = BGM;
            add_d   = save_vld_q ? save_add_q : BGM_START[bus.bgm_sel];
            track_d = {1'b0, save_vld_q ? save_trk_q : bus.bgm_sel};
          end else begin
            state_d = IDLE;
            add_d   = SILENT_ADDR;
            track_d = TRACK_SILENT;
          end
        end else if (tick && bus.data_over) begin
          add_d = add_q + addr_t'(1);
        end
      end

      default: state_d = WAIT_INIT;
    endcase

    // An accepted request overrides whatever the state logic chose above.
    if (take_req) begin
      state_d = SFX;
      add_d   = SFX_START[req_idx];
      track_d = {1'b1, req_idx};
      sfx_d   = req_idx;
      ack_d   = SFX_N'(1) << req_idx;
      if (state_q == BGM) begin
        save_add_d = add_q;
        save_trk_d = bgm_cur;
        save_vld_d = 1'b1;
      end else if (state_q == IDLE) begin
        save_vld_d = 1'b0;
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= WAIT_INIT;
      add_q      <= '0;
      track_q    <= TRACK_SILENT;
      sfx_q      <= '0;
      save_add_q <= '0;
      save_trk_q <= '0;
      save_vld_q <= 1'b0;
      ack_q      <= '0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      add_q      <= add_d;
      track_q    <= track_d;
      sfx_q      <= sfx_d;
      save_add_q <= save_add_d;
      save_trk_q <= save_trk_d;
      save_vld_q <= save_vld_d;
      ack_q      <= ack_d;
      init_q     <= 1'b1;
    end
  end

  assign bus.INIT     = init_q;
  assign bus.Add      = add_q;
  assign bus.sfx_ack  = ack_q;
  assign bus.sfx_busy = (state_q == SFX);
  assign bus.track_id = track_q;

endmodule

// File: tb/tb_audio_scheduler.sv
// -----------------------------------------------------------------------------
// tb_audio_scheduler
// Self-checking bench for audio_scheduler. Inputs change on the falling edge,
// outputs are compared on the falling edge after the DUT's rising edge.
// Expected outputs are queued when stimulus is applied and popped after the
// edge(s) that should produce them.
// -----------------------------------------------------------------------------
module tb_audio_scheduler;
  import audio_pkg::*;

  localparam int DIV   = 126;
  localparam int SFX_N = 3;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  audio_scheduler_if #(.SFX_N(SFX_N)) bus ();

  audio_scheduler #(.DIV(DIV), .SFX_N(SFX_N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [16:0] add;
    logic [2:0]  trk;
    logic [2:0]  ack;
    logic        busy;
  } exp_t;

  typedef struct {
    logic [2:0]  req;
    logic        en;
    logic [1:0]  sel;
    logic [2:0]  ack;
    logic [2:0]  trk;
    logic [16:0] add;
    logic        busy;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vt[11];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          t0    = 0;
  logic [16:0] force_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
    cyc += n;
  endtask

  // Cycles until the next rising edge that follows a sample tick.
  function automatic int to_tick();
    return DIV - ((cyc - t0) % DIV);
  endfunction

  task automatic sb_compare();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, ".Add"},      32'(bus.Add),      32'(e.add));
      check({e.name, ".track_id"}, 32'(bus.track_id), 32'(e.trk));
      check({e.name, ".sfx_ack"},  32'(bus.sfx_ack),  32'(e.ack));
      check({e.name, ".sfx_busy"}, 32'(bus.sfx_busy), 32'(e.busy));
    end
  endtask

  task automatic exp_step(input string name, input int n, input logic [16:0] add,
                          input logic [2:0] trk, input logic [2:0] ack, input logic busy);
    exp_t e;
    e.name = name;
    e.add  = add;
    e.trk  = trk;
    e.ack  = ack;
    e.busy = busy;
    sb_q.push_back(e);
    step(n);
    sb_compare();
  endtask

  // Places the DUT address at v during a cycle with no sample tick.
  task force_add(input logic [16:0] v);
    force_val = v;
    force dut.add_q = force_val;
    step(1);
    release dut.add_q;
  endtask

  task automatic bring_up();
    Reset           = 1'b0;
    bus.INIT_FINISH = 1'b0;
    bus.data_over   = 1'b1;
    bus.bgm_en      = 1'b0;
    bus.bgm_sel     = 2'd0;
    bus.sfx_req     = '0;
    step(2);
    Reset = 1'b1;
    step(4);
    bus.INIT_FINISH = 1'b1;
    exp_step("bring_up.idle", 1, SILENT_ADDR, 3'd7, 3'b000, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    //          req     en    sel   ack     trk   add              busy
    vt[0]  = '{3'b001, 1'b0, 2'd0, 3'b001, 3'd4, SFX_START[0],   1'b1};
    vt[1]  = '{3'b010, 1'b0, 2'd0, 3'b010, 3'd5, SFX_START[1],   1'b1};
    vt[2]  = '{3'b100, 1'b0, 2'd0, 3'b100, 3'd6, SFX_START[2],   1'b1};
    vt[3]  = '{3'b011, 1'b0, 2'd0, 3'b001, 3'd4, SFX_START[0],   1'b1};
    vt[4]  = '{3'b110, 1'b0, 2'd0, 3'b010, 3'd5, SFX_START[1],   1'b1};
    vt[5]  = '{3'b101, 1'b0, 2'd0, 3'b001, 3'd4, SFX_START[0],   1'b1};
    vt[6]  = '{3'b111, 1'b0, 2'd0, 3'b001, 3'd4, SFX_START[0],   1'b1};
    vt[7]  = '{3'b000, 1'b0, 2'd0, 3'b000, 3'd7, SILENT_ADDR,    1'b0};
    vt[8]  = '{3'b000, 1'b1, 2'd0, 3'b000, 3'd0, BGM_START[0],   1'b0};
    vt[9]  = '{3'b000, 1'b1, 2'd3, 3'b000, 3'd3, BGM_START[3],   1'b0};
    vt[10] = '{3'b100, 1'b1, 2'd2, 3'b100, 3'd6, SFX_START[2],   1'b1};

    // Reset state and WAIT_INIT behaviour.
    Reset           = 1'b0;
    bus.INIT_FINISH = 1'b0;
    bus.data_over   = 1'b1;
    bus.bgm_en      = 1'b1;
    bus.bgm_sel     = 2'd0;
    bus.sfx_req     = 3'b001;
    step(2);
    check("rst.INIT",     32'(bus.INIT),     32'd0);
    check("rst.Add",      32'(bus.Add),      32'd0);
    check("rst.track_id", 32'(bus.track_id), 32'd7);
    check("rst.sfx_ack",  32'(bus.sfx_ack),  32'd0);
    check("rst.sfx_busy", 32'(bus.sfx_busy), 32'd0);
    Reset = 1'b1;
    exp_step("wait_init", 3, 17'd0, 3'd7, 3'b000, 1'b0);
    check("wait_init.INIT", 32'(bus.INIT), 32'd1);
    bus.sfx_req     = '0;
    bus.bgm_en      = 1'b0;
    bus.INIT_FINISH = 1'b1;
    exp_step("init_done", 1, SILENT_ADDR, 3'd7, 3'b000, 1'b0);

    // Table: acceptance and priority from IDLE.
    for (int i = 0; i < 11; i++) begin
      bring_up();
      bus.sfx_req = vt[i].req;
      bus.bgm_en  = vt[i].en;
      bus.bgm_sel = vt[i].sel;
      exp_step($sformatf("vec%0d", i), 1, vt[i].add, vt[i].trk, vt[i].ack, vt[i].busy);
      bus.sfx_req = '0;
      exp_step($sformatf("vec%0d.hold", i), 1, vt[i].add, vt[i].trk, 3'b000, vt[i].busy);
    end

    // BGM start and sample-tick timing.
    bring_up();
    bus.bgm_sel = 2'd0;
    bus.bgm_en  = 1'b1;
    exp_step("bgm0.entry", 1, BGM_START[0], 3'd0, 3'b000, 1'b0);
    t0 = cyc;
    exp_step("bgm0.pre_tick",   DIV - 1, 17'd0, 3'd0, 3'b000, 1'b0);
    exp_step("bgm0.first_tick", 1,       17'd1, 3'd0, 3'b000, 1'b0);

    // Codec not ready for five ticks: address holds.
    bus.data_over = 1'b0;
    exp_step("stall5", 5 * DIV, 17'd1, 3'd0, 3'b000, 1'b0);
    bus.data_over = 1'b1;
    exp_step("stall_release", to_tick(), 17'd2, 3'd0, 3'b000, 1'b0);

    // Wrap at the end of track 0.
    force_add(17'd46094);
    exp_step("bgm0.wrap", to_tick(), 17'd0, 3'd0, 3'b000, 1'b0);

    // Track change takes effect on the next tick.
    bus.bgm_sel = 2'd2;
    exp_step("sel.pending", 1,         17'd0,        3'd0, 3'b000, 1'b0);
    exp_step("sel.switch",  to_tick(), BGM_START[2], 3'd2, 3'b000, 1'b0);
    exp_step("sel.advance", to_tick(), 17'(BGM_START[2] + 17'd1), 3'd2, 3'b000, 1'b0);

    // Music disabled: back to silence on the next tick.
    bus.bgm_en = 1'b0;
    exp_step("bgm_off.pending", 1,         17'(BGM_START[2] + 17'd1), 3'd2, 3'b000, 1'b0);
    exp_step("bgm_off.idle",    to_tick(), SILENT_ADDR, 3'd7, 3'b000, 1'b0);

    // SFX 1 interrupts BGM at 1000 and resumes it afterwards.
    bus.bgm_sel = 2'd0;
    bus.bgm_en  = 1'b1;
    exp_step("bgm.reenter", 1, BGM_START[0], 3'd0, 3'b000, 1'b0);
    t0 = cyc;
    force_add(17'd1000);
    exp_step("bgm.at1000", 1, 17'd1000, 3'd0, 3'b000, 1'b0);
    bus.sfx_req = 3'b110;
    exp_step("sfx1.accept", 1, SFX_START[1], 3'd5, 3'b010, 1'b1);
    bus.sfx_req = '0;
    exp_step("sfx1.ack_clear", 1,         SFX_START[1], 3'd5, 3'b000, 1'b1);
    exp_step("sfx1.tick1",     to_tick(), 17'(SFX_START[1] + 17'd1), 3'd5, 3'b000, 1'b1);
    bus.sfx_req = 3'b100;
    exp_step("sfx1.low_ignored",  1, 17'(SFX_START[1] + 17'd1), 3'd5, 3'b000, 1'b1);
    bus.sfx_req = 3'b010;
    exp_step("sfx1.same_ignored", 1, 17'(SFX_START[1] + 17'd1), 3'd5, 3'b000, 1'b1);
    bus.sfx_req = '0;
    n = to_tick() + DIV * (int'(SFX_END[1]) - int'(SFX_START[1]) - 2);
    exp_step("sfx1.at_end",      n,         SFX_END[1], 3'd5, 3'b000, 1'b1);
    exp_step("sfx1.resume",      to_tick(), 17'd1000,   3'd0, 3'b000, 1'b0);
    exp_step("bgm.after_resume", to_tick(), 17'd1001,   3'd0, 3'b000, 1'b0);

    // SFX 2 preempted by SFX 0; the BGM save survives the preemption.
    bus.sfx_req = 3'b100;
    exp_step("sfx2.accept", 1, SFX_START[2], 3'd6, 3'b100, 1'b1);
    bus.sfx_req = '0;
    exp_step("sfx2.tick", to_tick(), 17'(SFX_START[2] + 17'd1), 3'd6, 3'b000, 1'b1);
    bus.sfx_req = 3'b001;
    exp_step("sfx0.preempt", 1, SFX_START[0], 3'd4, 3'b001, 1'b1);
    bus.sfx_req = '0;
    n = to_tick() + DIV * (int'(SFX_END[0]) - int'(SFX_START[0]) - 1);
    exp_step("sfx0.at_end", n,         SFX_END[0], 3'd4, 3'b000, 1'b1);
    exp_step("sfx0.resume", to_tick(), 17'd1001,   3'd0, 3'b000, 1'b0);

    // A request on the final-sample tick wins over the BGM resume.
    bus.sfx_req = 3'b010;
    exp_step("sfx1b.accept", 1, SFX_START[1], 3'd5, 3'b010, 1'b1);
    bus.sfx_req = '0;
    n = to_tick() + DIV * (int'(SFX_END[1]) - int'(SFX_START[1]) - 1);
    exp_step("sfx1b.at_end", n, SFX_END[1], 3'd5, 3'b000, 1'b1);
    step(to_tick() - 1);
    bus.sfx_req = 3'b001;
    exp_step("race.req_wins", 1, SFX_START[0], 3'd4, 3'b001, 1'b1);
    bus.sfx_req = '0;
    exp_step("race.ack_clear", 1, SFX_START[0], 3'd4, 3'b000, 1'b1);

    // Reset in the middle of an effect: everything drops asynchronously.
    Reset = 1'b0;
    #1;
    check("midrst.INIT",     32'(bus.INIT),     32'd0);
    check("midrst.Add",      32'(bus.Add),      32'd0);
    check("midrst.track_id", 32'(bus.track_id), 32'd7);
    check("midrst.sfx_ack",  32'(bus.sfx_ack),  32'd0);
    check("midrst.sfx_busy", 32'(bus.sfx_busy), 32'd0);
    bus.INIT_FINISH = 1'b0;
    step(2);
    Reset = 1'b1;
    exp_step("post_rst.wait", 6, 17'd0, 3'd7, 3'b000, 1'b0);
    check("post_rst.INIT", 32'(bus.INIT), 32'd1);
    bus.INIT_FINISH = 1'b1;
    exp_step("post_rst.idle", 1, SILENT_ADDR,  3'd7, 3'b000, 1'b0);
    exp_step("post_rst.bgm",  1, BGM_START[0], 3'd0, 3'b000, 1'b0);
    t0 = cyc;

    // SFX started from IDLE has no saved BGM: resume at the selected track start.
    bus.bgm_en = 1'b0;
    exp_step("idle_again.pending", 1,         BGM_START[0], 3'd0, 3'b000, 1'b0);
    exp_step("idle_again",         to_tick(), SILENT_ADDR,  3'd7, 3'b000, 1'b0);
    bus.sfx_req = 3'b001;
    exp_step("nosave.accept", 1, SFX_START[0], 3'd4, 3'b001, 1'b1);
    t0 = cyc;
    bus.sfx_req = '0;
    bus.bgm_en  = 1'b1;
    bus.bgm_sel = 2'd1;
    n = to_tick() + DIV * (int'(SFX_END[0]) - int'(SFX_START[0]) - 1);
    exp_step("nosave.at_end", n,         SFX_END[0],   3'd4, 3'b000, 1'b1);
    exp_step("nosave.resume", to_tick(), BGM_START[1], 3'd1, 3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_scheduler.md
AUDIO_SCHEDULER -- requirements
Module: audio_scheduler

Interface
REQ-001 Parameter DIV, default 126: sample-rate divider; one sample tick every DIV Clk cycles.
REQ-002 Parameter SFX_N, default 3: number of sound-effect requesters.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 INIT_FINISH  input  1  codec initialisation complete.
REQ-006 data_over  input  1  codec ready for the next sample; level-sampled on tick cycles.
REQ-007 bgm_en  input  1  background music enable.
REQ-008 bgm_sel  input  2  background track index, 0..3.
REQ-009 sfx_req  input  SFX_N  one-shot sound-effect requests; bit 0 has highest priority.
REQ-010 INIT  output  1  codec initialisation request.
REQ-011 Add  output  17  audio ROM sample address.
REQ-012 sfx_ack  output  SFX_N  one-cycle acceptance pulse, one-hot.
REQ-013 sfx_busy  output  1  a sound effect is playing.
REQ-014 track_id  output  3  source of Add: 0..3 BGM track, 4..6 SFX 0..2, 7 silence.

Function
REQ-015 The FSM SHALL have the states WAIT_INIT, IDLE, BGM and SFX.
REQ-016 INIT SHALL be 1 in every state except reset.
REQ-017 WAIT_INIT SHALL go to IDLE on the first cycle with INIT_FINISH=1.
REQ-018 The tick counter SHALL run 0..DIV-1 and wrap; tick = (counter==DIV-1); the counter SHALL hold at 0 outside BGM/SFX.
REQ-019 In IDLE, Add SHALL equal SILENT_ADDR and track_id SHALL be 7.
REQ-020 IDLE SHALL go to BGM when bgm_en=1; Add SHALL load BGM_START[bgm_sel] on entry.
REQ-021 In BGM, on tick with data_over=1: if Add==BGM_END[cur], Add SHALL load BGM_START[cur]; otherwise Add SHALL increment by 1.
REQ-022 In BGM, on tick with data_over=0, Add SHALL hold.
REQ-023 A bgm_sel change SHALL be latched at the next tick, and Add SHALL restart at the new track's start address.
REQ-024 bgm_en=0 while in BGM SHALL return to IDLE on the next tick.
REQ-025 In IDLE or BGM, any sfx_req bit SHALL be accepted in that cycle: lowest set index wins, sfx_ack pulses for that bit only, and the state goes to SFX.
REQ-026 On SFX entry from BGM, the current BGM Add and track SHALL be saved.
REQ-027 Add SHALL load SFX_START[k] on SFX entry.
REQ-028 In SFX, Add SHALL advance as in REQ-021/REQ-022, without wrap.
REQ-029 On a tick with data_over=1 and Add==SFX_END[k], the FSM SHALL leave SFX.
REQ-030 On leaving SFX: if bgm_en=1, go to BGM and restore the saved Add/track (or BGM_START[bgm_sel] if none is saved); otherwise go to IDLE.
REQ-031 Requests arriving during SFX SHALL be accepted only if strictly higher priority (lower index): preempt, restart at the new SFX_START, and keep the BGM save unchanged; all other requests SHALL be ignored with no ack.
REQ-032 sfx_busy SHALL be 1 exactly while in SFX.
REQ-033 A request and the end-of-SFX tick in the same cycle: the request SHALL win (new SFX starts, no BGM resume).
REQ-034 Address arithmetic SHALL be 17-bit unsigned; Add SHALL never exceed the END of the active region.

Reset
REQ-035 On Reset=0 asynchronously: state=WAIT_INIT, counter=0, Add=0, sfx_ack=0, sfx_busy=0, track_id=7, saved Add=0, saved-valid=0, INIT=0.
REQ-036 Reset asserted mid-playback SHALL abandon all saved context; after release, a new INIT_FINISH SHALL be required.

Structure
REQ-037 Package audio_pkg SHALL hold the state enum, SILENT_ADDR=17'h1FFFF, and the BGM_START/BGM_END[4] and SFX_START/SFX_END[3] constant arrays (BGM0 = 0..46094).
REQ-038 The tick counter SHALL be the sub-module audio_rate_div (parameter DIV; outputs tick; input run).

Verification
REQ-039 Reset released, INIT_FINISH=1 at cycle 5, bgm_en=1, bgm_sel=0, data_over=1 -> Add=0 in BGM, and Add=1 after 126 cycles.
REQ-040 Force Add to 46094 in BGM0, one tick -> Add=0 (wrap), track_id=0.
REQ-041 BGM at Add=1000, sfx_req=3'b110 -> sfx_ack=3'b010, track_id=5, Add=SFX_START[1]; at SFX_END[1], Add=1000 restored.
REQ-042 SFX 2 playing, sfx_req=3'b001 -> preempt, ack=001, Add=SFX_START[0]; at end, the original BGM address is restored.
REQ-043 data_over=0 for 5 ticks -> Add unchanged; Reset pulsed mid-SFX -> all outputs at reset values; INIT_FINISH required again.
REQ-044 bgm_sel changes 0->2 mid-track -> Add=BGM_START[2] at the next tick, track_id=2.
